// File: rtl/key_filter.sv
// ---------------------------------------------------------------------------
// key_filter -- four-channel push-button debouncer with press/release pulses,
// debounced level and optional long-press detection.
//
// Build option:
//   LONG_PRESS_EN  when defined, each channel gets a 27-bit hold counter and
//                  key_long pulses once per press after LONG_MAX cycles held.
//                  When undefined, key_long is tied to 4'b0000.
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   key_in     in   [3:0] raw buttons, active-low, asynchronous to sys_clk
//   key_flag   out  [3:0] one-cycle pulse on debounced press
//   key_rel    out  [3:0] one-cycle pulse on debounced release
//   key_state  out  [3:0] debounced level, 1 = held
//   key_long   out  [3:0] one-cycle long-press pulse
// ---------------------------------------------------------------------------

// Per-channel debounce FSM. Outputs are registered; the output process
// computes their next values from the current and next state.
module key_filter_chan #(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [26:0] LONG_MAX = 27'd99_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_sync,
    output logic key_flag,
    output logic key_rel,
    output logic key_state,
    output logic key_long
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic        flag_nxt, rel_nxt, lvl_nxt;

    // State register plus registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            key_flag  <= 1'b0;
            key_rel   <= 1'b0;
            key_state <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_flag  <= flag_nxt;
            key_rel   <= rel_nxt;
            key_state <= lvl_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (!key_sync) state_nxt = PRESS_FILT;
            PRESS_FILT: begin
                if (key_sync)             state_nxt = IDLE;
                else if (cnt == CNT_MAX)  state_nxt = DOWN;
            end
            DOWN:       if (key_sync) state_nxt = REL_FILT;
            REL_FILT: begin
                if (!key_sync)            state_nxt = DOWN;
                else if (cnt == CNT_MAX)  state_nxt = IDLE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // Output / counter logic. The counter only advances while a filter
    // state persists, so it stops at CNT_MAX and is zero on every entry.
    always_comb begin
        cnt_nxt  = '0;
        flag_nxt = (state == PRESS_FILT) && (state_nxt == DOWN);
        rel_nxt  = (state == REL_FILT)   && (state_nxt == IDLE);
        lvl_nxt  = (state_nxt == DOWN) || (state_nxt == REL_FILT);
        if (((state == PRESS_FILT) || (state == REL_FILT)) && (state_nxt == state))
            cnt_nxt = cnt + 20'd1;
    end

`ifdef LONG_PRESS_EN
    logic [26:0] hold;
    logic        long_done;

    // Hold counter runs in DOWN, freezes in REL_FILT (so a release glitch
    // does not restart it) and clears elsewhere, which covers the clear on
    // entry from PRESS_FILT. key_long registers the saturated count seen on
    // the previous cycle; long_done suppresses repeats within one press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold      <= '0;
            long_done <= 1'b0;
            key_long  <= 1'b0;
        end else begin
            key_long <= 1'b0;
            case (state)
                DOWN: begin
                    if (hold != LONG_MAX) begin
                        hold <= hold + 27'd1;
                    end else if (!long_done) begin
                        key_long  <= 1'b1;
                        long_done <= 1'b1;
                    end
                end
                REL_FILT: ;
                default: begin
                    hold      <= '0;
                    long_done <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_long;
    assign unused_long = ^LONG_MAX;
    assign key_long    = 1'b0;
`endif

endmodule

module key_filter #(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [26:0] LONG_MAX = 27'd99_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_in,
    output logic [3:0] key_flag,
    output logic [3:0] key_rel,
    output logic [3:0] key_state,
    output logic [3:0] key_long
);

    logic [3:0] key_meta, key_sync;

    // Two-flop synchronizer; resets to released so no false press on reset exit
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta <= 4'b1111;
            key_sync <= 4'b1111;
        end else begin
            key_meta <= key_in;
            key_sync <= key_meta;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        key_filter_chan #(
            .CNT_MAX  (CNT_MAX),
            .LONG_MAX (LONG_MAX)
        ) u_chan (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key_sync  (key_sync[i]),
            .key_flag  (key_flag[i]),
            .key_rel   (key_rel[i]),
            .key_state (key_state[i]),
            .key_long  (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_filter.sv
// ---------------------------------------------------------------------------
// tb_key_filter -- directed self-checking bench for key_filter with
// CNT_MAX=4 (press/release at edge 8) and LONG_MAX=20 (key_long 21 edges
// after key_flag when LONG_PRESS_EN is defined).
// ---------------------------------------------------------------------------
module tb_key_filter;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [3:0] key_in;
    logic [3:0] key_flag, key_rel, key_state, key_long;

    int n_tests = 0;
    int n_fail  = 0;
    int ec      = 0;

    key_filter #(
        .CNT_MAX  (20'd4),
        .LONG_MAX (27'd20)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .key_flag  (key_flag),
        .key_rel   (key_rel),
        .key_state (key_state),
        .key_long  (key_long)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %b expected %b", tag, ec, got, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs changed after this are
    // sampled on the next edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
        ec++;
    endtask

    initial begin
        logic [3:0] exp_long;

        sys_rst_n = 1'b0;
        key_in    = 4'b1111;

        // Reset state
        repeat (3) begin
            step();
            check("rst_flag",  key_flag,  4'b0000);
            check("rst_rel",   key_rel,   4'b0000);
            check("rst_state", key_state, 4'b0000);
            check("rst_long",  key_long,  4'b0000);
        end
        sys_rst_n = 1'b1;
        repeat (3) step();

        // Single press on channel 0: flag and level rise on edge 8
        key_in = 4'b1110; ec = 0;
        repeat (10) begin
            step();
            check("p0_flag",  key_flag,  (ec == 8) ? 4'b0001 : 4'b0000);
            check("p0_state", key_state, (ec >= 8) ? 4'b0001 : 4'b0000);
        end
        key_in = 4'b1111; ec = 0;
        repeat (10) begin
            step();
            check("r0_rel",   key_rel,   (ec == 8) ? 4'b0001 : 4'b0000);
            check("r0_state", key_state, (ec <  8) ? 4'b0001 : 4'b0000);
        end

        // Short bounce on channel 1: no activity anywhere
        key_in = 4'b1101; ec = 0;
        repeat (12) begin
            step();
            if (ec == 3) key_in = 4'b1111;
            check("b1_flag",  key_flag,  4'b0000);
            check("b1_rel",   key_rel,   4'b0000);
            check("b1_state", key_state, 4'b0000);
        end

        // Channel 2: stable press, release glitch, then final release
        key_in = 4'b1011; ec = 0;
        repeat (10) begin
            step();
            check("p2_flag", key_flag, (ec == 8) ? 4'b0100 : 4'b0000);
        end
        key_in = 4'b1111; ec = 0;
        repeat (6) begin
            step();
            if (ec == 2) key_in = 4'b1011;
            check("g2_rel",   key_rel,   4'b0000);
            check("g2_state", key_state, 4'b0100);
        end
        key_in = 4'b1111; ec = 0;
        repeat (10) begin
            step();
            check("r2_rel",   key_rel,   (ec == 8) ? 4'b0100 : 4'b0000);
            check("r2_state", key_state, (ec <  8) ? 4'b0100 : 4'b0000);
        end

        // All four keys together
        key_in = 4'b0000; ec = 0;
        repeat (10) begin
            step();
            check("pa_flag", key_flag, (ec == 8) ? 4'b1111 : 4'b0000);
        end
        key_in = 4'b1111; ec = 0;
        repeat (10) begin
            step();
            check("ra_rel", key_rel, (ec == 8) ? 4'b1111 : 4'b0000);
        end

        // Reset mid-press aborts; held key re-debounces after reset release
        key_in = 4'b1110; ec = 0;
        repeat (5) begin
            step();
            check("pr_flag", key_flag, 4'b0000);
        end
        step();
        sys_rst_n = 1'b0;
        #1;
        check("pr_rst_state", key_state, 4'b0000);
        repeat (3) begin
            step();
            check("pr_rst_flag", key_flag, 4'b0000);
        end
        sys_rst_n = 1'b1; ec = 0;
        repeat (10) begin
            step();
            check("pr_flag2", key_flag, (ec == 8) ? 4'b0001 : 4'b0000);
        end
        key_in = 4'b1111;
        repeat (10) step();

        // Long press on channel 3
        key_in = 4'b0111; ec = 0;
        repeat (8) step();
        check("lp_flag", key_flag, 4'b1000);
        ec = 0;
        repeat (40) begin
            step();
`ifdef LONG_PRESS_EN
            exp_long = (ec == 21) ? 4'b1000 : 4'b0000;
`else
            exp_long = 4'b0000;
`endif
            check("lp_long", key_long, exp_long);
        end
        key_in = 4'b1111;
        repeat (10) begin
            step();
            check("lr_long", key_long, 4'b0000);
        end
        check("lr_state", key_state, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
